stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
- Counts elapsed time in MM:SS as BCD digits, driven by the toggling slow_clock output of the programmable clock divider.
- Both blocks run on the 100 MHz board clock. For a 1 Hz count, the divider is programmed with m = 49_999_999, so slow_clock rises once per second.
- Provides start/stop, clear and lap-hold control. Outputs feed the 7-segment/OLED display stage.

Parameters:
- MAX_MIN, 59, highest minutes value before wrap to 00:00 (legal range 1..99).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- slow_clock  in  1  divider output, synchronous to clk; each rising edge is one count tick
- start_stop  in  1  single-cycle pulse; toggles run/pause
- clear  in  1  single-cycle pulse; zero count, return to IDLE
- lap  in  1  single-cycle pulse; toggles display freeze
- sec_ones  out  4  displayed seconds units, BCD 0..9
- sec_tens  out  4  displayed seconds tens, BCD 0..5
- min_ones  out  4  displayed minutes units, BCD 0..9
- min_tens  out  4  displayed minutes tens, BCD 0..9
- running  out  1  high in RUN state
- lap_active  out  1  high while display is frozen
- wrap  out  1  one-cycle pulse when count wraps MAX_MIN:59 -> 00:00

Behaviour:

Tick generation:
- slow_q is a register of slow_clock.
- tick = slow_clock & ~slow_q, combinational inside the block.
- Reset value of slow_q is 0. If slow_clock is already 1 when reset is released, that first cycle produces one tick.

Internal counter:
- Four BCD registers: s1, s10, m1, m10.
- On a tick in RUN:
  - s1 increments. At 9 it goes to 0 and carries to s10.
  - s10 at 5 goes to 0 and carries to minutes.
  - Minutes form a 2-digit BCD value. If the minutes value equals MAX_MIN and seconds are 59, the whole count goes to 00:00 and wrap pulses high on the next cycle for exactly 1 cycle.
- The counter never holds a non-BCD value.

State machine (2 bits):
- IDLE: count is 00:00; running=0.
  - start_stop -> RUN.
- RUN: ticks advance the count; running=1.
  - start_stop -> PAUSE.
- PAUSE: ticks ignored; count held; running=0.
  - start_stop -> RUN.
- Any state, on clear: counter -> 00:00, state -> IDLE, lap_active -> 0.

Priority and simultaneous events:
- clear overrides start_stop, lap and tick in the same cycle.
- start_stop plus tick in the same cycle: the tick is evaluated against the current state.
  - IDLE -> RUN: the tick is not counted.
  - RUN -> PAUSE: the tick is counted.
- lap in IDLE is ignored.

Lap hold:
- lap while lap_active=0 (RUN or PAUSE): copy the current counter into the display registers and set lap_active=1. The counter keeps running underneath.
- lap while lap_active=1: lap_active=0; display resumes tracking the counter.
- When lap and tick coincide, the captured value is the pre-tick count.

Outputs:
- All outputs are registered.
- When lap_active=0, the display digits equal the counter with 1 cycle of latency after the update.
- When lap_active=1, the display digits hold the lap snapshot.
- running reflects the state register directly.

Reset (asynchronous assert, synchronous release via clk edge):
- All digits = 0, state = IDLE, running = 0, lap_active = 0, wrap = 0, slow_q = 0.
- A reset asserted mid-count aborts immediately; no tick in flight survives.

Test Plan:
- Reset release, start_stop pulse, 125 slow_clock rising edges -> digits 0,2,0,5 (02:05), running=1, wrap never pulsed.
- Simultaneous start_stop and tick from IDLE -> display stays 00:00 until the next tick, then 00:01.
- RUN at 00:10, start_stop -> PAUSE. 7 ticks -> still 00:10, running=0. start_stop, then 3 ticks -> 00:13.
- RUN at 00:20, lap -> display frozen at 00:20, lap_active=1. After 15 ticks, lap -> display 00:35, lap_active=0.
- MAX_MIN=1, RUN from 01:58, 2 ticks -> 01:59 then 00:00; wrap high for exactly 1 cycle.
- RUN at 03:07 with lap_active=1: assert clear and tick together -> 00:00, IDLE, lap_active=0. Then rst_n low mid-count -> all outputs 0 asynchronously (before the next clk edge).

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Control pulses and display outputs of the BCD stopwatch, bundled for the
// display stage (master) and the stopwatch core (slave).
interface stopwatch_bcd_if;
   logic       slow_clock;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       lap_active;
   logic       wrap;

   modport master (
      output slow_clock, start_stop, clear, lap,
      input  sec_ones, sec_tens, min_ones, min_tens, running, lap_active, wrap
   );

   modport slave (
      input  slow_clock, start_stop, clear, lap,
      output sec_ones, sec_tens, min_ones, min_tens, running, lap_active, wrap
   );
endinterface

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch advanced by rising edges of the divider's slow_clock,
// with start/stop, clear and lap-hold control.
module stopwatch_bcd #(
   parameter int MAX_MIN = 59
) (
   input logic          clk,
   input logic          rst_n,
   stopwatch_bcd_if.slave sw
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

   state_t     state, state_next;
   logic       slow_q;
   logic       tick;
   logic [3:0] s1, s10, m1, m10;
   logic [3:0] s1_next, s10_next, m1_next, m10_next;
   logic       wrap_next;
   logic       wrap_q;
   logic       lap_active_q;
   logic [3:0] disp_s1, disp_s10, disp_m1, disp_m10;

   assign tick = sw.slow_clock & ~slow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         slow_q <= 1'b0;
      end else begin
         state  <= state_next;
         slow_q <= sw.slow_clock;
      end
   end

   // Ticks are judged against the current state, so a start on a tick is not counted.
   always_comb begin
      state_next = state;
      if (sw.clear) begin
         state_next = IDLE;
      end else if (sw.start_stop) begin
         case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = PAUSE;
            PAUSE:   state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      s1_next   = s1;
      s10_next  = s10;
      m1_next   = m1;
      m10_next  = m10;
      wrap_next = 1'b0;
      if (sw.clear) begin
         s1_next  = 4'd0;
         s10_next = 4'd0;
         m1_next  = 4'd0;
         m10_next = 4'd0;
      end else if (tick && state == RUN) begin
         if (s1 != 4'd9) begin
            s1_next = s1 + 4'd1;
         end else begin
            s1_next = 4'd0;
            if (s10 != 4'd5) begin
               s10_next = s10 + 4'd1;
            end else begin
               s10_next = 4'd0;
               // Minutes are compared as two BCD digits against MAX_MIN.
               if (m10 == MAX_TENS && m1 == MAX_ONES) begin
                  m1_next   = 4'd0;
                  m10_next  = 4'd0;
                  wrap_next = 1'b1;
               end else if (m1 != 4'd9) begin
                  m1_next = m1 + 4'd1;
               end else begin
                  m1_next  = 4'd0;
                  m10_next = m10 + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 4'd0;
         s10    <= 4'd0;
         m1     <= 4'd0;
         m10    <= 4'd0;
         wrap_q <= 1'b0;
      end else begin
         s1     <= s1_next;
         s10    <= s10_next;
         m1     <= m1_next;
         m10    <= m10_next;
         wrap_q <= wrap_next;
      end
   end

   // Lap captures the pre-tick count; releasing it reloads from the live counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_active_q <= 1'b0;
         disp_s1      <= 4'd0;
         disp_s10     <= 4'd0;
         disp_m1      <= 4'd0;
         disp_m10     <= 4'd0;
      end else if (sw.clear) begin
         lap_active_q <= 1'b0;
         disp_s1      <= 4'd0;
         disp_s10     <= 4'd0;
         disp_m1      <= 4'd0;
         disp_m10     <= 4'd0;
      end else if (sw.lap && state != IDLE) begin
         lap_active_q <= ~lap_active_q;
         disp_s1      <= s1;
         disp_s10     <= s10;
         disp_m1      <= m1;
         disp_m10     <= m10;
      end else if (!lap_active_q) begin
         disp_s1      <= s1;
         disp_s10     <= s10;
         disp_m1      <= m1;
         disp_m10     <= m10;
      end
   end

   assign sw.sec_ones   = disp_s1;
   assign sw.sec_tens   = disp_s10;
   assign sw.min_ones   = disp_m1;
   assign sw.min_tens   = disp_m10;
   assign sw.running    = (state == RUN);
   assign sw.lap_active = lap_active_q;
   assign sw.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: a MAX_MIN=59 instance and a MAX_MIN=1
// instance receive identical stimulus; expected values are hand-computed.
module tb_stopwatch_bcd;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   wrapCntA = 0;
   int   wrapCntB = 0;

   stopwatch_bcd_if ifA ();
   stopwatch_bcd_if ifB ();

   stopwatch_bcd #(.MAX_MIN(59)) dut_a (.clk(clk), .rst_n(rst_n), .sw(ifA));
   stopwatch_bcd #(.MAX_MIN(1))  dut_b (.clk(clk), .rst_n(rst_n), .sw(ifB));

   wire [15:0] dispA = {ifA.min_tens, ifA.min_ones, ifA.sec_tens, ifA.sec_ones};
   wire [15:0] dispB = {ifB.min_tens, ifB.min_ones, ifB.sec_tens, ifB.sec_ones};

   always #5 clk = ~clk;

   // Wrap is sampled mid-cycle so each high cycle is counted exactly once.
   always @(negedge clk) begin
      if (ifA.wrap === 1'b1) wrapCntA++;
      if (ifB.wrap === 1'b1) wrapCntB++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle with the given controls, then one idle cycle so slow_clock
   // drops and the display catches up with the counter.
   task automatic applyStimulus(input logic ss, input logic clr,
                                input logic lp, input logic sc);
      ifA.start_stop = ss;  ifB.start_stop = ss;
      ifA.clear      = clr; ifB.clear      = clr;
      ifA.lap        = lp;  ifB.lap        = lp;
      ifA.slow_clock = sc;  ifB.slow_clock = sc;
      step();
      ifA.start_stop = 1'b0; ifB.start_stop = 1'b0;
      ifA.clear      = 1'b0; ifB.clear      = 1'b0;
      ifA.lap        = 1'b0; ifB.lap        = 1'b0;
      ifA.slow_clock = 1'b0; ifB.slow_clock = 1'b0;
      step();
   endtask

   task automatic tickN(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      ifA.start_stop = 1'b0; ifB.start_stop = 1'b0;
      ifA.clear      = 1'b0; ifB.clear      = 1'b0;
      ifA.lap        = 1'b0; ifB.lap        = 1'b0;
      ifA.slow_clock = 1'b0; ifB.slow_clock = 1'b0;

      repeat (3) step();
      checkOutput("reset_digits", 32'(dispA), 32'h0000);
      checkOutput("reset_running", 32'(ifA.running), 32'd0);
      checkOutput("reset_lap", 32'(ifA.lap_active), 32'd0);
      checkOutput("reset_wrap", 32'(ifA.wrap), 32'd0);
      rst_n = 1'b1;
      step();

      // Count to 02:05 from reset
      wrapCntA = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(125);
      checkOutput("count_0205", 32'(dispA), 32'h0205);
      checkOutput("count_running", 32'(ifA.running), 32'd1);
      checkOutput("count_no_wrap", 32'(wrapCntA), 32'd0);

      // Start and tick together from IDLE
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("clear_digits", 32'(dispA), 32'h0000);
      checkOutput("clear_running", 32'(ifA.running), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("start_tick_digits", 32'(dispA), 32'h0000);
      checkOutput("start_tick_running", 32'(ifA.running), 32'd1);
      tickN(1);
      checkOutput("first_tick", 32'(dispA), 32'h0001);

      // Pause and resume
      tickN(9);
      checkOutput("at_0010", 32'(dispA), 32'h0010);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(7);
      checkOutput("pause_hold", 32'(dispA), 32'h0010);
      checkOutput("pause_running", 32'(ifA.running), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(3);
      checkOutput("resume_0013", 32'(dispA), 32'h0013);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("stop_tick_counted", 32'(dispA), 32'h0014);
      checkOutput("stop_tick_running", 32'(ifA.running), 32'd0);

      // Lap ignored in IDLE, then lap hold while running
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("idle_lap_ignored", 32'(ifA.lap_active), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(20);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lap_frozen", 32'(dispA), 32'h0020);
      checkOutput("lap_active_set", 32'(ifA.lap_active), 32'd1);
      tickN(15);
      checkOutput("lap_still_frozen", 32'(dispA), 32'h0020);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lap_release", 32'(dispA), 32'h0035);
      checkOutput("lap_active_clr", 32'(ifA.lap_active), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("lap_tick_pre", 32'(dispA), 32'h0035);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lap_tick_post", 32'(dispA), 32'h0036);

      // Wrap at MAX_MIN=1 instance, 01:58 -> 01:59 -> 00:00
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(118);
      checkOutput("wrapb_0158", 32'(dispB), 32'h0158);
      wrapCntA = 0;
      wrapCntB = 0;
      tickN(1);
      checkOutput("wrapb_0159", 32'(dispB), 32'h0159);
      checkOutput("wrapb_not_yet", 32'(wrapCntB), 32'd0);
      tickN(1);
      checkOutput("wrapb_0000", 32'(dispB), 32'h0000);
      checkOutput("a_at_0200", 32'(dispA), 32'h0200);
      repeat (4) step();
      checkOutput("wrapb_one_cycle", 32'(wrapCntB), 32'd1);
      checkOutput("wrapa_none", 32'(wrapCntA), 32'd0);
      checkOutput("wrapb_running", 32'(ifB.running), 32'd1);

      // Clear with tick while lapped at 03:07, then async reset mid-count
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(187);
      checkOutput("at_0307", 32'(dispA), 32'h0307);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lap_0307", 32'(ifA.lap_active), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("clear_tick_digits", 32'(dispA), 32'h0000);
      checkOutput("clear_tick_running", 32'(ifA.running), 32'd0);
      checkOutput("clear_tick_lap", 32'(ifA.lap_active), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tickN(5);
      checkOutput("pre_reset_0005", 32'(dispA), 32'h0005);
      step();
      rst_n = 1'b0;
      #2;
      checkOutput("async_digits", 32'(dispA), 32'h0000);
      checkOutput("async_running", 32'(ifA.running), 32'd0);
      checkOutput("async_lap", 32'(ifA.lap_active), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
